// File: rtl/cam_access_ctrl.sv
// rtl/cam_access_ctrl.sv - sequencer/arbiter sharing a ternary CAM between one writer and one looker
// Lookups flow through a token pipeline; writes run IDLE->ISSUE->BUSY->DONE with a per-entry valid mask.
module cam_access_ctrl #(
  parameter int DATA_WIDTH   = 35,
  parameter int ADDR_WIDTH   = 5,
  parameter int LOOKUP_LAT   = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_req,
  input  logic                       wr_inval,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [DATA_WIDTH-1:0]      wr_care,
  output logic                       wr_ack,
  input  logic                       lk_valid,
  input  logic [DATA_WIDTH-1:0]      lk_data,
  output logic                       lk_ready,
  output logic                       res_valid,
  output logic                       res_hit,
  output logic                       res_multi,
  output logic [ADDR_WIDTH-1:0]      res_addr,
  output logic                       cam_start_write,
  output logic [ADDR_WIDTH-1:0]      cam_waddr,
  output logic [DATA_WIDTH-1:0]      cam_wdata,
  output logic [DATA_WIDTH-1:0]      cam_wcare,
  input  logic                       cam_ready,
  output logic [DATA_WIDTH-1:0]      cam_lookup_data,
  input  logic [(1<<ADDR_WIDTH)-1:0] cam_match_lines
);
  localparam int WORDS = 1 << ADDR_WIDTH;
  localparam int CW    = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  state_t                state_q;
  logic [WORDS-1:0]      valid_q;
  logic [LOOKUP_LAT-1:0] tok_q, tok_d;
  logic [CW-1:0]         starve_q;
  logic                  busy_wait_q, seen_low_q;
  logic                  wr_ack_q, res_valid_q, res_hit_q, res_multi_q, cam_start_write_q;
  logic [ADDR_WIDTH-1:0] res_addr_q, cam_waddr_q;
  logic [DATA_WIDTH-1:0] cam_wdata_q, cam_wcare_q, cam_lookup_data_q;

  logic                  req_live, starved, write_grant, lk_accept, wr_start;
  logic [WORDS-1:0]      masked;
  logic                  hit_d, multi_d;
  logic [ADDR_WIDTH-1:0] addr_d;

  always_comb begin
    // The requester still holds wr_req in the ack cycle; ignore it there so one request is served once.
    req_live    = wr_req & ~wr_ack_q;
    starved     = (starve_q == CW'(STARVE_LIMIT));
    write_grant = (state_q == IDLE) & req_live & (~lk_valid | starved);
    lk_ready    = cam_ready & (state_q == IDLE) & ~write_grant;
    lk_accept   = lk_valid & lk_ready;
    wr_start    = write_grant & cam_ready & (tok_q == '0);
    tok_d       = tok_q << 1;
    tok_d[0]    = lk_accept;
    masked      = cam_match_lines & valid_q;
    hit_d       = |masked;
    multi_d     = |(masked & (masked - WORDS'(1)));
    addr_d      = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (masked[i]) addr_d = ADDR_WIDTH'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= IDLE;
      valid_q           <= '0;
      tok_q             <= '0;
      starve_q          <= '0;
      busy_wait_q       <= 1'b0;
      seen_low_q        <= 1'b0;
      wr_ack_q          <= 1'b0;
      res_valid_q       <= 1'b0;
      res_hit_q         <= 1'b0;
      res_multi_q       <= 1'b0;
      res_addr_q        <= '0;
      cam_start_write_q <= 1'b0;
      cam_waddr_q       <= '0;
      cam_wdata_q       <= '0;
      cam_wcare_q       <= '0;
      cam_lookup_data_q <= '0;
    end else begin
      wr_ack_q          <= 1'b0;
      cam_start_write_q <= 1'b0;
      tok_q             <= tok_d;
      res_valid_q       <= tok_q[LOOKUP_LAT-1];
      if (tok_q[LOOKUP_LAT-1]) begin
        res_hit_q   <= hit_d;
        res_multi_q <= multi_d;
        res_addr_q  <= addr_d;
      end
      if (lk_accept) cam_lookup_data_q <= lk_data;
      if (req_live & lk_accept & ~starved) starve_q <= starve_q + CW'(1);

      case (state_q)
        IDLE: begin
          if (wr_start) begin
            valid_q[wr_addr] <= 1'b0;
            if (wr_inval) begin
              wr_ack_q <= 1'b1;
              starve_q <= '0;
            end else begin
              cam_waddr_q       <= wr_addr;
              cam_wdata_q       <= wr_data;
              cam_wcare_q       <= wr_care;
              cam_start_write_q <= 1'b1;
              state_q           <= ISSUE;
            end
          end
        end
        ISSUE: begin
          busy_wait_q <= 1'b0;
          seen_low_q  <= 1'b0;
          state_q     <= BUSY;
        end
        BUSY: begin
          // A CAM that never drops ready is assumed to have finished after two cycles.
          if (seen_low_q) begin
            if (cam_ready) state_q <= DONE;
          end else if (!cam_ready) begin
            seen_low_q <= 1'b1;
          end else if (busy_wait_q) begin
            state_q <= DONE;
          end else begin
            busy_wait_q <= 1'b1;
          end
        end
        DONE: begin
          valid_q[cam_waddr_q] <= 1'b1;
          wr_ack_q             <= 1'b1;
          starve_q             <= '0;
          state_q              <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_ack          = wr_ack_q;
  assign res_valid       = res_valid_q;
  assign res_hit         = res_hit_q;
  assign res_multi       = res_multi_q;
  assign res_addr        = res_addr_q;
  assign cam_start_write = cam_start_write_q;
  assign cam_waddr       = cam_waddr_q;
  assign cam_wdata       = cam_wdata_q;
  assign cam_wcare       = cam_wcare_q;
  assign cam_lookup_data = cam_lookup_data_q;
endmodule

// File: tb/tb_cam_access_ctrl.sv
// tb/tb_cam_access_ctrl.sv - randomized bench for cam_access_ctrl with a behavioural CAM and result model
module tb_cam_access_ctrl;
  localparam int DW    = 35;
  localparam int AW    = 5;
  localparam int WORDS = 1 << AW;
  localparam int LAT   = 1;
  localparam int LIM   = 8;
  localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

  logic clk = 1'b0;
  logic rst, wr_req, wr_inval, wr_ack, lk_valid, lk_ready;
  logic [AW-1:0] wr_addr, res_addr, cam_waddr;
  logic [DW-1:0] wr_data, wr_care, lk_data, cam_wdata, cam_wcare, cam_lookup_data;
  logic res_valid, res_hit, res_multi, cam_start_write;
  logic cam_ready = 1'b1;
  logic [WORDS-1:0] cam_match_lines;

  cam_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOOKUP_LAT(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_inval(wr_inval), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_care(wr_care), .wr_ack(wr_ack), .lk_valid(lk_valid),
    .lk_data(lk_data), .lk_ready(lk_ready), .res_valid(res_valid), .res_hit(res_hit),
    .res_multi(res_multi), .res_addr(res_addr), .cam_start_write(cam_start_write),
    .cam_waddr(cam_waddr), .cam_wdata(cam_wdata), .cam_wcare(cam_wcare),
    .cam_ready(cam_ready), .cam_lookup_data(cam_lookup_data), .cam_match_lines(cam_match_lines)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural CAM: ternary match on stored key/care, write lands when ready returns.
  logic [DW-1:0] mkey [WORDS];
  logic [DW-1:0] mcare [WORDS];
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data, pend_care;
  int busy_left = 0;
  int busy_len = 2;
  logic nodrop = 1'b0;

  always_comb begin
    for (int i = 0; i < WORDS; i++)
      cam_match_lines[i] = (((cam_lookup_data ^ mkey[i]) & mcare[i]) == '0);
  end

  always @(posedge clk) begin
    if (cam_start_write) begin
      if (nodrop) begin
        mkey[cam_waddr]  <= cam_wdata;
        mcare[cam_waddr] <= cam_wcare;
      end else begin
        pend_addr <= cam_waddr;
        pend_data <= cam_wdata;
        pend_care <= cam_wcare;
        cam_ready <= 1'b0;
        busy_left <= busy_len;
      end
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) begin
        mkey[pend_addr]  <= pend_data;
        mcare[pend_addr] <= pend_care;
        cam_ready        <= 1'b1;
      end
    end
  end

  // Reference: which committed entries a key hits, lowest index first.
  logic [WORDS-1:0] rvalid;
  logic [DW-1:0] rkey [WORDS];
  logic [DW-1:0] rcare [WORDS];
  logic cur_inval;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data, cur_care;

  typedef struct packed {
    logic          hit;
    logic          multi;
    logic [AW-1:0] addr;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];

  function automatic exp_t ref_lookup(input logic [DW-1:0] key);
    exp_t e;
    int n = 0;
    e = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (rvalid[i] && (((key ^ rkey[i]) & rcare[i]) == '0)) begin
        if (n == 0) e.addr = AW'(i);
        n++;
      end
    end
    e.hit   = (n > 0);
    e.multi = (n > 1);
    return e;
  endfunction

  int ack_cnt = 0, ack_cyc = 0, sw_cnt = 0, sw_cyc = 0, acc_cnt = 0, starve_cnt = 0;
  logic last_hit = 1'b0, last_multi = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic in_write = 1'b0;
  logic [AW+2*DW-1:0] w_snap;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      exp_q.delete();
      rvalid   = '0;
      in_write = 1'b0;
    end else begin
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("res_spurious", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("res_hit", 64'(res_hit), 64'(e.hit));
          check_eq("res_multi", 64'(res_multi), 64'(e.multi));
          check_eq("res_addr", 64'(res_addr), 64'(e.addr));
          check_eq("res_latency", 64'(cyc - e.cyc), 64'(LAT + 1));
          last_hit = res_hit; last_multi = res_multi; last_addr = res_addr;
        end
      end
      if (wr_ack) begin
        ack_cnt++;
        ack_cyc  = cyc;
        in_write = 1'b0;
        if (cur_inval) rvalid[cur_addr] = 1'b0;
        else begin
          rvalid[cur_addr] = 1'b1;
          rkey[cur_addr]   = cur_data;
          rcare[cur_addr]  = cur_care;
        end
      end
      if (lk_valid && lk_ready) begin
        e = ref_lookup(lk_data);
        e.cyc = cyc;
        exp_q.push_back(e);
        acc_cnt++;
        if (wr_req && !wr_ack) starve_cnt++;
      end
      if (!cam_ready) check_eq("lk_ready_cam_busy", 64'(lk_ready), 64'd0);
      if (cam_start_write) begin
        sw_cnt++;
        sw_cyc   = cyc;
        in_write = 1'b1;
        w_snap   = {cam_waddr, cam_wdata, cam_wcare};
        check_eq("cam_waddr", 64'(cam_waddr), 64'(cur_addr));
        check_eq("cam_wdata", 64'(cam_wdata), 64'(cur_data));
        check_eq("cam_wcare", 64'(cam_wcare), 64'(cur_care));
      end else if (in_write) begin
        check_eq("lk_ready_in_write", 64'(lk_ready), 64'd0);
        check_eq("cam_w_stable", 64'({cam_waddr, cam_wdata, cam_wcare} == w_snap), 64'd1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pick_key();
    case ($urandom_range(0, 3))
      0: return DW'('hAB);
      1: return DW'('h1);
      2: return DW'('h55);
      default: return DW'({$urandom(), $urandom()});
    endcase
  endfunction

  task automatic wait_lk_ready(input string tag);
    int w = 0;
    while (1) begin
      @(negedge clk);
      if (lk_ready) break;
      if (++w > 100) begin
        check_eq(tag, 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic do_lookup(input logic [DW-1:0] key);
    step();
    lk_valid = 1'b1;
    lk_data  = key;
    wait_lk_ready("lookup_timeout");
    step();
    lk_valid = 1'b0;
  endtask

  task automatic stream(input int n);
    step();
    lk_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      lk_data = pick_key();
      wait_lk_ready("stream_timeout");
      step();
    end
    lk_valid = 1'b0;
  endtask

  task automatic do_write(input logic inv, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] c);
    int w = 0;
    step();
    cur_inval = inv; cur_addr = a; cur_data = d; cur_care = c;
    wr_inval = inv; wr_addr = a; wr_data = d; wr_care = c;
    busy_len = $urandom_range(1, 3);
    wr_req = 1'b1;
    while (1) begin
      @(negedge clk);
      if (wr_ack) break;
      if (++w > 60) begin
        check_eq("write_timeout", 64'd0, 64'd1);
        break;
      end
    end
    step();
    wr_req = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, a0, st0, acc0, w;
    logic [DW-1:0] k;
    rst = 1'b0; wr_req = 1'b0; wr_inval = 1'b0; wr_addr = '0; wr_data = '0; wr_care = '0;
    lk_valid = 1'b0; lk_data = '0;
    cur_inval = 1'b0; cur_addr = '0; cur_data = '0; cur_care = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("rst_wr_ack", 64'(wr_ack), 64'd0);
    check_eq("rst_start_write", 64'(cam_start_write), 64'd0);
    check_eq("rst_lookup_data", 64'(cam_lookup_data), 64'd0);
    check_eq("rst_res_addr", 64'(res_addr), 64'd0);
    step();
    rst = 1'b1;

    // Single write then a hitting lookup.
    s0 = sw_cnt; a0 = ack_cnt;
    do_write(1'b0, AW'(3), DW'('hAB), ALL1);
    check_eq("t1_start_pulses", 64'(sw_cnt - s0), 64'd1);
    check_eq("t1_acks", 64'(ack_cnt - a0), 64'd1);
    do_lookup(DW'('hAB));
    wait_drain();
    check_eq("t1_hit", 64'(last_hit), 64'd1);
    check_eq("t1_addr", 64'(last_addr), 64'd3);
    check_eq("t1_multi", 64'(last_multi), 64'd0);

    // Wildcard entries and invalidate.
    do_write(1'b0, AW'(5), DW'($urandom()), '0);
    do_write(1'b0, AW'(9), DW'($urandom()), '0);
    do_lookup(DW'({$urandom(), $urandom()}));
    wait_drain();
    check_eq("t2_addr", 64'(last_addr), 64'd5);
    check_eq("t2_multi", 64'(last_multi), 64'd1);
    do_write(1'b1, AW'(5), '0, '0);
    do_lookup(DW'({$urandom(), $urandom()}));
    wait_drain();
    check_eq("t2_inval_addr", 64'(last_addr), 64'd9);
    check_eq("t2_inval_multi", 64'(last_multi), 64'd0);

    // Starvation: a continuous lookup stream lets the write in after exactly LIM accepts.
    st0 = starve_cnt; acc0 = acc_cnt;
    fork
      stream(30);
      begin
        repeat (3) @(posedge clk);
        do_write(1'b0, AW'(12), DW'({$urandom(), $urandom()}), ALL1);
      end
    join
    wait_drain();
    check_eq("starve_accepts", 64'(starve_cnt - st0), 64'(LIM));
    check_eq("stream_accepts", 64'(acc_cnt - acc0), 64'd30);

    // Overwrite of a valid entry.
    do_write(1'b1, AW'(9), '0, '0);
    do_write(1'b1, AW'(12), '0, '0);
    do_write(1'b0, AW'(3), DW'('h1), ALL1);
    do_lookup(DW'('hAB));
    wait_drain();
    check_eq("ow_old_miss", 64'(last_hit), 64'd0);
    do_lookup(DW'('h1));
    wait_drain();
    check_eq("ow_new_hit", 64'(last_hit), 64'd1);
    check_eq("ow_new_addr", 64'(last_addr), 64'd3);

    // Reset during BUSY while the CAM stays internally busy.
    a0 = ack_cnt;
    step();
    cur_inval = 1'b0; cur_addr = AW'(20); cur_data = DW'('h55); cur_care = ALL1;
    wr_inval = 1'b0; wr_addr = AW'(20); wr_data = DW'('h55); wr_care = ALL1;
    busy_len = 8;
    wr_req = 1'b1;
    w = 0;
    while (!cam_start_write && w < 40) begin
      @(negedge clk);
      w++;
    end
    check_eq("rst_mid_started", 64'(cam_start_write), 64'd1);
    @(negedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;
    wr_req = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstw_start_write", 64'(cam_start_write), 64'd0);
    check_eq("rstw_wr_ack", 64'(wr_ack), 64'd0);
    check_eq("rstw_res_valid", 64'(res_valid), 64'd0);
    check_eq("rstw_waddr", 64'(cam_waddr), 64'd0);
    check_eq("rstw_wdata", 64'(cam_wdata), 64'd0);
    check_eq("rstw_lk_ready", 64'(lk_ready), 64'd0);
    do_lookup(DW'('h1));
    do_lookup(DW'('h55));
    wait_drain();
    check_eq("rstw_old_key_miss", 64'(last_hit), 64'd0);
    check_eq("rstw_no_ack", 64'(ack_cnt - a0), 64'd0);

    // CAM that never drops ready.
    nodrop = 1'b1;
    k = DW'({$urandom(), $urandom()});
    do_write(1'b0, AW'(7), k, ALL1);
    check_eq("nodrop_ack_latency", 64'(ack_cyc - sw_cyc), 64'd4);
    do_lookup(k);
    wait_drain();
    check_eq("nodrop_hit", 64'(last_hit), 64'd1);
    check_eq("nodrop_addr", 64'(last_addr), 64'd7);
    nodrop = 1'b0;

    // Randomized mix of writes, invalidates, lookups and contended bursts.
    for (int i = 0; i < 80; i++) begin
      logic [DW-1:0] c;
      c = ($urandom_range(0, 2) == 0) ? DW'({$urandom(), $urandom()}) : ALL1;
      case ($urandom_range(0, 4))
        0: do_lookup(pick_key());
        1: stream($urandom_range(2, 5));
        2: do_write(1'b0, AW'($urandom_range(0, 7)), pick_key(), c);
        3: do_write(1'b1, AW'($urandom_range(0, 7)), '0, '0);
        default: fork
          stream($urandom_range(3, 12));
          do_write(1'b0, AW'($urandom_range(0, 7)), pick_key(), c);
        join
      endcase
    end
    wait_drain();

    // Every entry valid and matching.
    for (int a = 0; a < WORDS; a++) do_write(1'b0, AW'(a), DW'($urandom()), '0);
    do_lookup(DW'({$urandom(), $urandom()}));
    wait_drain();
    check_eq("full_hit", 64'(last_hit), 64'd1);
    check_eq("full_addr", 64'(last_addr), 64'd0);
    check_eq("full_multi", 64'(last_multi), 64'd1);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cam_access_ctrl.md
Name: cam_access_ctrl

Overview:
- Sequencer and arbiter in front of the stitched ternary CAM.
- Shares the CAM between one write/invalidate requester and one lookup requester.
- Drives the CAM's start_write/ready write protocol and keeps a per-entry valid mask.
- Priority-encodes masked match lines into a registered hit/address result.

Parameters:
DATA_WIDTH, 35, CAM key width (blocks x 7).
ADDR_WIDTH, 5, CAM address width; WORDS = 2**ADDR_WIDTH.
LOOKUP_LAT, 1, cycles from cam_lookup_data change to valid cam_match_lines (1..4).
STARVE_LIMIT, 8, consecutive cycles a pending write may lose to lookups before it wins.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
wr_req  in  1  write/invalidate request; hold with payload until wr_ack
wr_inval  in  1  1 = invalidate entry wr_addr only, no CAM write
wr_addr  in  ADDR_WIDTH  target entry
wr_data  in  DATA_WIDTH  key
wr_care  in  DATA_WIDTH  care mask (1 = bit compared)
wr_ack  out  1  one-cycle pulse when the request is complete
lk_valid  in  1  lookup request
lk_data  in  DATA_WIDTH  lookup key
lk_ready  out  1  lookup accepted when lk_valid & lk_ready
res_valid  out  1  one-cycle result strobe
res_hit  out  1  at least one valid entry matched
res_multi  out  1  more than one valid entry matched
res_addr  out  ADDR_WIDTH  lowest matching index (0 if no hit)
cam_start_write  out  1  to CAM start_write
cam_waddr  out  ADDR_WIDTH  to CAM waddr
cam_wdata  out  DATA_WIDTH  to CAM wdata
cam_wcare  out  DATA_WIDTH  to CAM wcare
cam_ready  in  1  from CAM ready
cam_lookup_data  out  DATA_WIDTH  to CAM lookup_data
cam_match_lines  in  WORDS  from CAM match_lines

Behaviour:
Reset (rst=0 at an edge):
- All outputs and registers go to 0; valid mask all 0; FSM to IDLE.
- Lookup pipeline is flushed; starvation counter cleared.

Lookup path:
- lk_ready = cam_ready & (state==IDLE) & ~write_grant.
- On accept edge E0, cam_lookup_data <= lk_data; a token enters a LOOKUP_LAT-deep shift register.
- At edge E0+LOOKUP_LAT, sample cam_match_lines & valid_mask and register res_*. res_valid is high for the following cycle.
- Back-to-back lookups give one result per cycle, in order.

Arbitration (IDLE state):
- Lookups win by default.
- A starvation counter increments each cycle wr_req is high and a lookup is accepted, saturating at STARVE_LIMIT.
- write_grant = wr_req & (lk_valid==0 | counter==STARVE_LIMIT). While write_grant is high, lk_ready=0.
- A write leaves IDLE only when the lookup pipeline is empty. Counter clears on wr_ack.

Invalidate (wr_inval=1, granted, pipeline empty):
- Clears valid_mask[wr_addr] and pulses wr_ack in the same edge.
- No CAM activity; FSM stays in IDLE.

Write FSM:
- IDLE -> ISSUE: latch addr/data/care into cam_w* and clear valid_mask[addr]. cam_w* hold until DONE.
- ISSUE: cam_start_write=1 for exactly one cycle -> BUSY.
- BUSY: wait for cam_ready=0. If it is not seen within 2 cycles, treat the write as done (-> DONE). Otherwise wait for cam_ready=1 -> DONE.
- DONE: set valid_mask[addr], pulse wr_ack -> IDLE.

Boundary conditions:
- Overwriting a valid entry: the entry reads invalid from ISSUE until DONE.
- A lookup never observes a partial write.
- Simultaneous wr_req and lk_valid with counter < STARVE_LIMIT: the lookup wins.
- All WORDS valid and matching: res_addr=0, res_multi=1.
- Reset mid-write: FSM returns to IDLE and cam_start_write drops. No new operation starts until cam_ready=1, because the CAM may still be busy internally.
- wr_ack is never asserted for a request dropped by reset.

Test Plan:
- Reset, then write addr 3, key 0x0000000AB, care all-ones. Expect one cam_start_write pulse and wr_ack after cam_ready returns. A subsequent lookup of 0x0000000AB gives res_hit=1, res_addr=3, res_multi=0, with res_valid exactly LOOKUP_LAT+1 cycles after accept.
- Write addr 5 and addr 9 with care=0 (match all). Lookup any key -> res_addr=5, res_multi=1. Invalidate 5, then lookup -> res_addr=9, res_multi=0.
- Hold lk_valid high continuously and raise wr_req. Expect exactly 8 lookups accepted, then lk_ready=0. The write completes, then lookups resume. Results stay in order with no drops.
- During BUSY, check lk_ready=0 and that cam_waddr/cam_wdata/cam_wcare stay stable. An overwrite of valid addr 3 with key 0x1 gives a miss for lookup 0xAB and a hit for 0x1.
- Assert rst=0 for one cycle during BUSY. Expect all outputs 0, valid mask cleared, and no wr_ack. lk_ready stays 0 until cam_ready=1, and a lookup of the old key misses.
- CAM model that never drops cam_ready: the write completes via the 2-cycle rule, and wr_ack follows 4 cycles after grant.
